// File: rtl/axil_read_queue_if.sv
// ---------------------------------------------------------------------------
// axil_read_queue_if
//   Bundles the configuration-side request/response signals and the
//   AXI4-Lite AR/R channel signals of axil_read_queue.
//
//   Parameters
//     ADDR_W : address width
//     DATA_W : data width (32 or 64)
//
//   Modports
//     master : the read-queue side (drives AR/R master signals and the
//              configuration-side response outputs)
//     slave  : the environment side (configuration requester plus the
//              AXI4-Lite slave / interconnect)
// ---------------------------------------------------------------------------
interface axil_read_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Configuration (request) side
    logic              s_axi_cfg_rvalid;
    logic [ADDR_W-1:0] s_axi_cfg_raddr;
    logic              s_axi_cfg_rready;
    logic [DATA_W-1:0] s_axi_cfg_rdata;
    logic [1:0]        s_axi_cfg_rresp;
    logic              s_axi_cfg_rdv;
    logic              s_axi_cfg_rerr;
    logic              s_axi_cfg_busy;

    // AXI4-Lite read address / read data channels
    logic [ADDR_W-1:0] s_axi_araddr;
    logic [2:0]        s_axi_arprot;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic              s_axi_rvalid;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rready;

    modport master (
        input  s_axi_cfg_rvalid, s_axi_cfg_raddr,
        output s_axi_cfg_rready, s_axi_cfg_rdata, s_axi_cfg_rresp,
        output s_axi_cfg_rdv, s_axi_cfg_rerr, s_axi_cfg_busy,
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rvalid, s_axi_rdata, s_axi_rresp,
        output s_axi_rready
    );

    modport slave (
        output s_axi_cfg_rvalid, s_axi_cfg_raddr,
        input  s_axi_cfg_rready, s_axi_cfg_rdata, s_axi_cfg_rresp,
        input  s_axi_cfg_rdv, s_axi_cfg_rerr, s_axi_cfg_busy,
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rvalid, s_axi_rdata, s_axi_rresp,
        input  s_axi_rready
    );
endinterface

// File: rtl/axil_read_queue.sv
// ---------------------------------------------------------------------------
// axil_read_queue
//   AXI4-Lite read master fed by a request FIFO. Byte addresses pushed on the
//   configuration side are queued, issued one at a time on AR/R (data-width
//   aligned), and the returned data plus RRESP are reported back with a
//   one-cycle strobe. Responses come back in request order.
//
//   Parameters
//     ADDR_W      : address width (>= 12)
//     DATA_W      : data width, 32 or 64
//     FIFO_DEPTH  : request queue depth, power of 2, >= 2
//     TIMEOUT_CYC : watchdog limit in cycles (>= 4), watchdog build only
//
//   Ports
//     s_axi_aclk   : sole clock, rising edge
//     s_axi_areset : synchronous active-high reset
//     bus          : axil_read_queue_if.master
//                    cfg side : rvalid/raddr in, rready/rdata/rresp/rdv/
//                               rerr/busy out
//                    AXI side : araddr/arprot/arvalid/rready out,
//                               arready/rvalid/rdata/rresp in
//
//   Build option
//     AXIL_READ_QUEUE_TIMEOUT_EN : adds a per-phase watchdog. A stalled AR or
//     R phase is abandoned after TIMEOUT_CYC cycles with an error strobe
//     (rresp = 2'b10, rdata = 0) and the block parks in FAULT until reset.
// ---------------------------------------------------------------------------
module axil_read_queue #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic                s_axi_aclk,
    input logic                s_axi_areset,
    axil_read_queue_if.master  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // Clears the byte-offset bits below the data-bus width.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_W / 8 - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
`ifdef AXIL_READ_QUEUE_TIMEOUT_EN
        , ST_FAULT
`endif
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------
    // Request FIFO: pointers carry one extra wrap bit for full/empty.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              cfg_ready;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // Ready depends only on the registered fill level, never on a pop in
    // the same cycle, so it carries no combinational path from the FSM.
`ifdef AXIL_READ_QUEUE_TIMEOUT_EN
    assign cfg_ready = !full && (state != ST_FAULT);
`else
    assign cfg_ready = !full;
`endif
    assign push = bus.s_axi_cfg_rvalid && cfg_ready;

    always_ff @(posedge s_axi_aclk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= bus.s_axi_cfg_raddr;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered AXI and response outputs
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] araddr_q;
    logic              arvalid_q;
    logic              rready_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              rdv_q;
    logic              rerr_q;

    logic              ar_done;
    logic              r_done;

`ifdef AXIL_READ_QUEUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] wd_cnt;
    logic             wd_expired;
    logic             timeout;

    assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Restarts on every state change, so ADDR and DATA are timed
    // independently from their own entry.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            wd_cnt <= '0;
        end else if (state_next != state) begin
            wd_cnt <= '0;
        end else if (state == ST_ADDR || state == ST_DATA) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and phase events
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        ar_done    = 1'b0;
        r_done     = 1'b0;
`ifdef AXIL_READ_QUEUE_TIMEOUT_EN
        timeout    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (arvalid_q && bus.s_axi_arready) begin
                    ar_done    = 1'b1;
                    state_next = ST_DATA;
                end
`ifdef AXIL_READ_QUEUE_TIMEOUT_EN
                else if (wd_expired) begin
                    timeout    = 1'b1;
                    state_next = ST_FAULT;
                end
`endif
            end
            ST_DATA: begin
                if (rready_q && bus.s_axi_rvalid) begin
                    r_done     = 1'b1;
                    state_next = ST_IDLE;
                end
`ifdef AXIL_READ_QUEUE_TIMEOUT_EN
                else if (wd_expired) begin
                    timeout    = 1'b1;
                    state_next = ST_FAULT;
                end
`endif
            end
`ifdef AXIL_READ_QUEUE_TIMEOUT_EN
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers driven by the phase events
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rdv_q     <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            rdv_q  <= 1'b0;
            rerr_q <= 1'b0;
            if (pop) begin
                araddr_q  <= mem[rd_ptr[PTR_W-1:0]] & ALIGN_MASK;
                arvalid_q <= 1'b1;
            end
            if (ar_done) begin
                arvalid_q <= 1'b0;
                rready_q  <= 1'b1;
            end
            if (r_done) begin
                rready_q <= 1'b0;
                rdata_q  <= bus.s_axi_rdata;
                rresp_q  <= bus.s_axi_rresp;
                rdv_q    <= 1'b1;
                rerr_q   <= (bus.s_axi_rresp != 2'b00);
            end
`ifdef AXIL_READ_QUEUE_TIMEOUT_EN
            if (timeout) begin
                arvalid_q <= 1'b0;
                rready_q  <= 1'b0;
                rdata_q   <= '0;
                rresp_q   <= 2'b10;
                rdv_q     <= 1'b1;
                rerr_q    <= 1'b1;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    assign bus.s_axi_cfg_rready = cfg_ready;
    assign bus.s_axi_cfg_rdata  = rdata_q;
    assign bus.s_axi_cfg_rresp  = rresp_q;
    assign bus.s_axi_cfg_rdv    = rdv_q;
    assign bus.s_axi_cfg_rerr   = rerr_q;
    // The FSM is back in IDLE during the response strobe; busy is held
    // through that cycle so it only falls once the result is delivered.
    assign bus.s_axi_cfg_busy   = (state != ST_IDLE) || !empty || rdv_q;

    assign bus.s_axi_araddr     = araddr_q;
    assign bus.s_axi_arprot     = 3'b000;
    assign bus.s_axi_arvalid    = arvalid_q;
    assign bus.s_axi_rready     = rready_q;

endmodule

// File: tb/tb_axil_read_queue.sv
// ---------------------------------------------------------------------------
// tb_axil_read_queue
//   Directed bench for axil_read_queue. A 32-bit instance is exercised
//   against a small reactive AXI4-Lite slave; a 64-bit instance checks
//   address alignment. Build with AXIL_READ_QUEUE_TIMEOUT_EN to cover the
//   watchdog (TIMEOUT_CYC = 16).
// ---------------------------------------------------------------------------
module tb_axil_read_queue;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_read_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    axil_read_queue_if #(.ADDR_W(32), .DATA_W(64)) bus64 ();

    axil_read_queue #(
        .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)
    ) dut (
        .s_axi_aclk  (clk),
        .s_axi_areset(rst),
        .bus         (bus)
    );

    axil_read_queue #(
        .ADDR_W(32), .DATA_W(64), .FIFO_DEPTH(4), .TIMEOUT_CYC(1024)
    ) dut64 (
        .s_axi_aclk  (clk),
        .s_axi_areset(rst),
        .bus         (bus64)
    );

    // ---------------- slave model for the 32-bit instance ----------------
    logic        arready_en = 1'b0;
    logic        hold_r     = 1'b0;
    logic        echo       = 1'b0;
    logic        slv_rvalid;
    logic [31:0] slv_rdata;
    logic [1:0]  slv_rresp;
    int          slv_idx;
    logic [31:0] data_tab [8];
    logic [1:0]  resp_tab [8];

    assign bus.s_axi_arready = arready_en;
    assign bus.s_axi_rvalid  = slv_rvalid;
    assign bus.s_axi_rdata   = slv_rdata;
    assign bus.s_axi_rresp   = slv_rresp;

    always @(posedge clk) begin
        if (rst) begin
            slv_rvalid <= 1'b0;
            slv_rdata  <= '0;
            slv_rresp  <= '0;
            slv_idx    <= 0;
        end else begin
            if (slv_rvalid && bus.s_axi_rready) slv_rvalid <= 1'b0;
            if (bus.s_axi_arvalid && bus.s_axi_arready) begin
                slv_rvalid <= !hold_r;
                slv_rdata  <= echo ? {16'hA5A5, bus.s_axi_araddr[15:0]}
                                   : data_tab[slv_idx[2:0]];
                slv_rresp  <= echo ? 2'b00 : resp_tab[slv_idx[2:0]];
                slv_idx    <= slv_idx + 1;
            end
        end
    end

    assign bus64.s_axi_arready = 1'b0;
    assign bus64.s_axi_rvalid  = 1'b0;
    assign bus64.s_axi_rdata   = '0;
    assign bus64.s_axi_rresp   = '0;

    // ---------------- monitors ----------------
    logic [31:0] ar_log [$];
    logic [31:0] rdv_data [$];
    logic [1:0]  rdv_resp [$];
    logic        rdv_err [$];
    int          orphan_rerr = 0;

    always @(posedge clk) begin
        if (!rst && bus.s_axi_arvalid && bus.s_axi_arready)
            ar_log.push_back(bus.s_axi_araddr);
    end

    always @(negedge clk) begin
        if (bus.s_axi_cfg_rdv) begin
            rdv_data.push_back(bus.s_axi_cfg_rdata);
            rdv_resp.push_back(bus.s_axi_cfg_rresp);
            rdv_err.push_back(bus.s_axi_cfg_rerr);
        end else if (bus.s_axi_cfg_rerr) begin
            orphan_rerr = orphan_rerr + 1;
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return bus.s_axi_arvalid;
            1:       return bus.s_axi_cfg_rdv;
            2:       return bus.s_axi_rready;
            3:       return bus.s_axi_cfg_rready;
            default: return bus64.s_axi_arvalid;
        endcase
    endfunction

    // Waits (at negedges) for a probed signal; an expired budget is a failure.
    task automatic wait_for(input string tag, input int sel, input int budget, output int n);
        n = 0;
        while (!probe(sel) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!probe(sel)) check({tag, "_timeout"}, 64'(probe(sel)), 64'd1);
    endtask

    task automatic push(input logic [31:0] a, input int budget, output bit ok);
        bus.s_axi_cfg_rvalid = 1'b1;
        bus.s_axi_cfg_raddr  = a;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            ok = bus.s_axi_cfg_rready;
            @(negedge clk);
        end
        bus.s_axi_cfg_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_rdv_count(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (rdv_data.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_count"}, 64'(rdv_data.size()), 64'(target));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  lat;
        int  n;
        int  base;
        int  base_ar;
        bit  ok;
        logic [31:0] addr;

        bus.s_axi_cfg_rvalid   = 1'b0;
        bus.s_axi_cfg_raddr    = '0;
        bus64.s_axi_cfg_rvalid = 1'b0;
        bus64.s_axi_cfg_raddr  = '0;
        for (int i = 0; i < 8; i++) begin
            data_tab[i] = '0;
            resp_tab[i] = '0;
        end

        // Reset values
        do_reset();
        check("rst_araddr",   64'(bus.s_axi_araddr),    64'h0);
        check("rst_arvalid",  64'(bus.s_axi_arvalid),   64'h0);
        check("rst_rready",   64'(bus.s_axi_rready),    64'h0);
        check("rst_arprot",   64'(bus.s_axi_arprot),    64'h0);
        check("rst_cfg_data", 64'(bus.s_axi_cfg_rdata), 64'h0);
        check("rst_cfg_resp", 64'(bus.s_axi_cfg_rresp), 64'h0);
        check("rst_rdv",      64'(bus.s_axi_cfg_rdv),   64'h0);
        check("rst_rerr",     64'(bus.s_axi_cfg_rerr),  64'h0);
        check("rst_busy",     64'(bus.s_axi_cfg_busy),  64'h0);
        check("rst_cfg_rdy",  64'(bus.s_axi_cfg_rready), 64'h1);

        // Alignment on the 64-bit instance: 0x107 -> 0x100
        bus64.s_axi_cfg_rvalid = 1'b1;
        bus64.s_axi_cfg_raddr  = 32'h0000_0107;
        @(negedge clk);
        bus64.s_axi_cfg_rvalid = 1'b0;
        wait_for("al64_arvalid", 4, 10, n);
        check("al64_araddr", 64'(bus64.s_axi_araddr), 64'h0000_0100);

        // Single read, immediately ready slave
        do_reset();
        arready_en  = 1'b1;
        echo        = 1'b0;
        data_tab[0] = 32'hDEAD_BEEF;
        resp_tab[0] = 2'b00;
        base = rdv_data.size();
        bus.s_axi_cfg_rvalid = 1'b1;
        bus.s_axi_cfg_raddr  = 32'h0000_0104;
        @(negedge clk);
        bus.s_axi_cfg_rvalid = 1'b0;
        lat = 1;
        check("t1_busy_queued", 64'(bus.s_axi_cfg_busy), 64'h1);
        wait_for("t1_arvalid", 0, 10, n);
        lat += n;
        check("t1_ar_latency", 64'(lat), 64'd2);
        check("t1_araddr",     64'(bus.s_axi_araddr), 64'h104);
        check("t1_arprot",     64'(bus.s_axi_arprot), 64'h0);
        wait_for("t1_rdv", 1, 10, n);
        lat += n;
        check("t1_rdv_latency", 64'(lat), 64'd4);
        check("t1_rdata",  64'(bus.s_axi_cfg_rdata), 64'hDEAD_BEEF);
        check("t1_rresp",  64'(bus.s_axi_cfg_rresp), 64'h0);
        check("t1_rerr",   64'(bus.s_axi_cfg_rerr),  64'h0);
        check("t1_busy_at_rdv", 64'(bus.s_axi_cfg_busy), 64'h1);
        @(negedge clk);
        check("t1_rdv_pulse", 64'(bus.s_axi_cfg_rdv),  64'h0);
        check("t1_busy_fall", 64'(bus.s_axi_cfg_busy), 64'h0);
        check("t1_rdata_hold", 64'(bus.s_axi_cfg_rdata), 64'hDEAD_BEEF);
        check("t1_rdv_total", 64'(rdv_data.size() - base), 64'd1);

        // Queue full: one request is popped into ADDR, four fill the FIFO,
        // and the next one is held off until a pop frees a slot.
        do_reset();
        arready_en = 1'b0;
        echo       = 1'b1;
        base    = rdv_data.size();
        base_ar = ar_log.size();
        for (int i = 0; i < 5; i++) begin
            push(32'h10 * (i + 1), 4, ok);
            check($sformatf("qf_push%0d", i), 64'(ok), 64'h1);
        end
        check("qf_full_rdy",  64'(bus.s_axi_cfg_rready), 64'h0);
        check("qf_ar_head",   64'(bus.s_axi_araddr),     64'h10);
        check("qf_busy",      64'(bus.s_axi_cfg_busy),   64'h1);
        bus.s_axi_cfg_rvalid = 1'b1;
        bus.s_axi_cfg_raddr  = 32'h60;
        repeat (3) @(negedge clk);
        check("qf_held_rdy", 64'(bus.s_axi_cfg_rready), 64'h0);
        arready_en = 1'b1;
        wait_for("qf_slot", 3, 20, n);
        @(negedge clk);
        bus.s_axi_cfg_rvalid = 1'b0;
        wait_rdv_count("qf_rdv", base + 6, 100);
        check("qf_ar_count", 64'(ar_log.size() - base_ar), 64'd6);
        for (int i = 0; i < 6; i++) begin
            addr = 32'h10 * (i + 1);
            if (base_ar + i < ar_log.size())
                check($sformatf("qf_ar_order%0d", i), 64'(ar_log[base_ar + i]), 64'(addr));
            if (base + i < rdv_data.size())
                check($sformatf("qf_data%0d", i), 64'(rdv_data[base + i]),
                      64'({16'hA5A5, addr[15:0]}));
        end

        // Error response followed by a normal read
        do_reset();
        arready_en  = 1'b1;
        echo        = 1'b0;
        data_tab[0] = 32'h0000_1234;
        resp_tab[0] = 2'b10;
        data_tab[1] = 32'hCAFE_F00D;
        resp_tab[1] = 2'b00;
        base = rdv_data.size();
        push(32'h200, 4, ok);
        push(32'h204, 4, ok);
        wait_rdv_count("er_rdv", base + 2, 50);
        if (rdv_data.size() >= base + 2) begin
            check("er_rdata0", 64'(rdv_data[base]),     64'h1234);
            check("er_rresp0", 64'(rdv_resp[base]),     64'h2);
            check("er_rerr0",  64'(rdv_err[base]),      64'h1);
            check("er_rdata1", 64'(rdv_data[base + 1]), 64'hCAFE_F00D);
            check("er_rresp1", 64'(rdv_resp[base + 1]), 64'h0);
            check("er_rerr1",  64'(rdv_err[base + 1]),  64'h0);
        end

        // Reset while waiting in DATA with two requests queued
        do_reset();
        arready_en = 1'b1;
        hold_r     = 1'b1;
        base = rdv_data.size();
        push(32'h300, 4, ok);
        push(32'h304, 4, ok);
        push(32'h308, 4, ok);
        wait_for("mr_data", 2, 10, n);
        check("mr_busy_before", 64'(bus.s_axi_cfg_busy), 64'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mr_rready",  64'(bus.s_axi_rready),   64'h0);
        check("mr_arvalid", 64'(bus.s_axi_arvalid),  64'h0);
        check("mr_busy",    64'(bus.s_axi_cfg_busy), 64'h0);
        rst    = 1'b0;
        hold_r = 1'b0;
        repeat (6) @(negedge clk);
        check("mr_queue_empty", 64'(bus.s_axi_arvalid),  64'h0);
        check("mr_busy_after",  64'(bus.s_axi_cfg_busy), 64'h0);
        check("mr_no_rdv",      64'(rdv_data.size() - base), 64'd0);

`ifdef AXIL_READ_QUEUE_TIMEOUT_EN
        // Watchdog: AR never accepted
        do_reset();
        arready_en = 1'b0;
        base = rdv_data.size();
        push(32'h400, 4, ok);
        wait_for("wd_arvalid", 0, 10, n);
        wait_for("wd_rdv", 1, 40, n);
        check("wd_latency", 64'(n), 64'd16);
        check("wd_rerr",    64'(bus.s_axi_cfg_rerr),  64'h1);
        check("wd_rresp",   64'(bus.s_axi_cfg_rresp), 64'h2);
        check("wd_rdata",   64'(bus.s_axi_cfg_rdata), 64'h0);
        repeat (3) @(negedge clk);
        check("wd_fault_rdy",  64'(bus.s_axi_cfg_rready), 64'h0);
        check("wd_fault_busy", 64'(bus.s_axi_cfg_busy),   64'h1);
        check("wd_arvalid",    64'(bus.s_axi_arvalid),    64'h0);
        push(32'h404, 5, ok);
        check("wd_fault_push", 64'(ok), 64'h0);
        check("wd_one_rdv", 64'(rdv_data.size() - base), 64'd1);
        do_reset();
        check("wd_rst_rdy", 64'(bus.s_axi_cfg_rready), 64'h1);
`else
        // Without the watchdog a stalled AR phase waits indefinitely
        do_reset();
        arready_en = 1'b0;
        base = rdv_data.size();
        push(32'h400, 4, ok);
        repeat (40) @(negedge clk);
        check("nw_arvalid", 64'(bus.s_axi_arvalid), 64'h1);
        check("nw_busy",    64'(bus.s_axi_cfg_busy), 64'h1);
        check("nw_no_rdv",  64'(rdv_data.size() - base), 64'd0);
        do_reset();
`endif

        check("orphan_rerr", 64'(orphan_rerr), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
